layer_out_serializer: RTL
=========================

LAYER_OUT_SERIALIZER -- requirements
Module: layer_out_serializer

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 128: number of parallel neuron outputs captured per frame (>=2).
REQ-002 SHALL have parameter ROM_WIDTH, default 8: width of each neuron activation output.
REQ-003 SHALL have parameter DATA_WIDTH, default 8: width of the serial output word fed to the next layer's myinput; ROM_WIDTH <= DATA_WIDTH.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  one-cycle pulse: all neuron outputs valid (AND of the layer's outvalid signals).
REQ-007 in_data  input  NUM_NEURONS*ROM_WIDTH  flat activation bus; neuron k occupies bits [k*ROM_WIDTH +: ROM_WIDTH].
REQ-008 out_ready  input  1  downstream accepts the current word; tie high when driving neuron myinput directly.
REQ-009 clr_err  input  1  clears the sticky overflow flag.
REQ-010 out_data  output  DATA_WIDTH  serial activation word (to next-layer myinput).
REQ-011 out_valid  output  1  out_data valid (to next-layer myinputValid).
REQ-012 out_last  output  1  high with the word of neuron NUM_NEURONS-1.
REQ-013 busy  output  1  high while either bank holds an unsent frame.
REQ-014 overflow  output  1  sticky; a frame was dropped.

Function
REQ-015 SHALL hold two frame banks (A, B), each NUM_NEURONS x ROM_WIDTH, each with a FULL/EMPTY flag.
REQ-016 SHALL keep a write-bank selector and a read-bank selector; both reset to A and toggle after each capture and after each completed frame respectively.
REQ-017 On in_valid, if the write bank is EMPTY, or it is releasing this cycle (REQ-023), SHALL capture all of in_data into it in that cycle, set it FULL, and toggle the write selector.
REQ-018 On in_valid with the write bank FULL and not releasing, SHALL drop the frame, leave both banks unchanged, and set overflow.
REQ-019 Read-side FSM states: IDLE, STREAM. IDLE -> STREAM when the read bank is FULL. STREAM -> IDLE after the last-word handshake if the other bank is EMPTY; STREAM -> STREAM (other bank, index 0) if it is FULL.
REQ-020 out_data, out_valid, and out_last SHALL be registered. The first word SHALL appear with out_valid high exactly 2 cycles after the in_valid edge that captured into an idle, empty block.
REQ-021 Word order SHALL be neuron 0 first, ascending to NUM_NEURONS-1; the index counter is $clog2(NUM_NEURONS) bits and resets to 0 at each frame start.
REQ-022 Each word SHALL be the ROM_WIDTH activation zero-extended to DATA_WIDTH, because activations are unsigned.
REQ-023 Handshake: a word transfers when out_valid & out_ready; while out_valid & !out_ready, out_data, out_valid, and out_last SHALL hold stable; the bank is released (set EMPTY) on the out_last transfer.
REQ-024 With out_ready held high, the block SHALL emit one word per cycle with no gaps within a frame and no bubble between back-to-back FULL banks.
REQ-025 Capture and release of the same bank in the same cycle: the set SHALL win; the bank remains FULL with the new frame.
REQ-026 clr_err SHALL clear overflow; if clr_err and a new overflow occur in the same cycle, overflow SHALL be set.
REQ-027 busy SHALL equal (bank A FULL) OR (bank B FULL).

Reset
REQ-028 rst SHALL set both banks EMPTY, both selectors to A, the FSM to IDLE, the index to 0, and out_valid, out_last, overflow, and out_data to 0; bank contents are not reset.
REQ-029 rst asserted mid-frame SHALL abort the stream; no further words SHALL be emitted, and in_valid in the reset cycle SHALL be ignored.

Verification
REQ-030 NUM_NEURONS=4, in_data={8'h04,8'h03,8'h02,8'h01}, in_valid pulse, out_ready=1 -> out_data 01,02,03,04 on consecutive cycles starting 2 cycles later; out_last only with 04; busy then 0.
REQ-031 Two in_valid pulses 2 cycles apart, out_ready=1 -> 8 contiguous words, both frames in order, no overflow.
REQ-032 out_ready=0 after an in_valid; then send two more in_valid -> the third frame is dropped and overflow=1; clr_err -> overflow=0.
REQ-033 out_ready toggling 1,0,0,1 during a frame -> each word is held while stalled; no duplicates or skips.
REQ-034 rst pulse after the 2nd word of a frame -> out_valid=0 next cycle; a fresh in_valid then restarts at neuron 0.
REQ-035 ROM_WIDTH=4, DATA_WIDTH=8, activation 4'hF -> out_data=8'h0F.

Source files
------------

// File: rtl/layer_out_serializer.sv
// rtl/layer_out_serializer.sv - double-banked capture of a layer's parallel activations,
// streamed out one zero-extended word per cycle with a valid/ready handshake.
module layer_out_serializer #(
  parameter int NUM_NEURONS = 128,
  parameter int ROM_WIDTH   = 8,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  logic [NUM_NEURONS*ROM_WIDTH-1:0] in_data,
  input  logic                             out_ready,
  input  logic                             clr_err,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_valid,
  output logic                             out_last,
  output logic                             busy,
  output logic                             overflow
);

  localparam int IW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  typedef enum logic {IDLE, STREAM} state_e;

  state_e                state_q, state_d;
  logic                  full_a_q, full_a_d, full_b_q, full_b_d;
  logic                  wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  last_ld_q, last_ld_d;
  logic                  ov_q, ov_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;

  logic [ROM_WIDTH-1:0]  bank_a_q [NUM_NEURONS];
  logic [ROM_WIDTH-1:0]  bank_b_q [NUM_NEURONS];

  logic                  rd_full, oth_full, wr_full, wr_rel;
  logic                  release_s, rel_a, rel_b, cap, cap_a, cap_b;
  logic [ROM_WIDTH-1:0]  rd_word, oth_word0;

  // Bank bookkeeping: a capture into a bank that is releasing this cycle wins over the release.
  always_comb begin
    rd_full   = rd_sel_q ? full_b_q : full_a_q;
    oth_full  = rd_sel_q ? full_a_q : full_b_q;
    rd_word   = rd_sel_q ? bank_b_q[idx_q] : bank_a_q[idx_q];
    oth_word0 = rd_sel_q ? bank_a_q[0] : bank_b_q[0];
    release_s = (state_q == STREAM) && last_ld_q && out_valid_q && out_ready;
    rel_a     = release_s && !rd_sel_q;
    rel_b     = release_s && rd_sel_q;
    wr_full   = wr_sel_q ? full_b_q : full_a_q;
    wr_rel    = wr_sel_q ? rel_b : rel_a;
    cap       = in_valid && (!wr_full || wr_rel);
    cap_a     = cap && !wr_sel_q;
    cap_b     = cap && wr_sel_q;
    full_a_d  = cap_a ? 1'b1 : (rel_a ? 1'b0 : full_a_q);
    full_b_d  = cap_b ? 1'b1 : (rel_b ? 1'b0 : full_b_q);
    wr_sel_d  = wr_sel_q ^ cap;
    rd_sel_d  = rd_sel_q ^ release_s;
    ov_d      = (in_valid && !cap) ? 1'b1 : (clr_err ? 1'b0 : ov_q);
  end

  // last_ld_q marks that the frame's final word sits in the output register awaiting transfer.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_ld_d   = last_ld_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    case (state_q)
      IDLE: begin
        if (rd_full) begin
          state_d   = STREAM;
          idx_d     = '0;
          last_ld_d = 1'b0;
        end
      end
      STREAM: begin
        if (!last_ld_q) begin
          if (!out_valid_q || out_ready) begin
            out_data_d  = DATA_WIDTH'(rd_word);
            out_valid_d = 1'b1;
            out_last_d  = (idx_q == IW'(NUM_NEURONS - 1));
            if (idx_q == IW'(NUM_NEURONS - 1)) last_ld_d = 1'b1;
            else                               idx_d     = idx_q + IW'(1);
          end
        end else if (release_s) begin
          last_ld_d  = 1'b0;
          out_last_d = 1'b0;
          if (oth_full) begin
            out_data_d  = DATA_WIDTH'(oth_word0);
            out_valid_d = 1'b1;
            idx_d       = IW'(1);
          end else begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            idx_d       = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      full_a_q    <= 1'b0;
      full_b_q    <= 1'b0;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      idx_q       <= '0;
      last_ld_q   <= 1'b0;
      ov_q        <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      full_a_q    <= full_a_d;
      full_b_q    <= full_b_d;
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      idx_q       <= idx_d;
      last_ld_q   <= last_ld_d;
      ov_q        <= ov_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_NEURONS; k++) begin
      if (cap_a && !rst) bank_a_q[k] <= in_data[k*ROM_WIDTH +: ROM_WIDTH];
      if (cap_b && !rst) bank_b_q[k] <= in_data[k*ROM_WIDTH +: ROM_WIDTH];
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign overflow  = ov_q;
  assign busy      = full_a_q | full_b_q;

endmodule
